// File: rtl/fsm_pkg.sv
// Shared FSM state encodings.
// pktz_state_e: flit packetizer control states.
package fsm_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RREQ      = 3'd1,
        LOAD      = 3'd2,
        SEND_HEAD = 3'd3,
        SEND_BODY = 3'd4,
        SEND_TAIL = 3'd5
    } pktz_state_e;

endpackage

// File: rtl/ni_pkg.sv
// Network-interface shared types: request packet layout seen at the
// request FIFO read port (one head, NI_BODY_FLITS body flits, one tail).
package ni_pkg;

    localparam int unsigned NI_FLIT_W     = 16;
    localparam int unsigned NI_BODY_FLITS = 3;

    typedef struct packed {
        logic [NI_FLIT_W-1:0]                     head;
        logic [NI_BODY_FLITS-1:0][NI_FLIT_W-1:0]  body;
        logic [NI_FLIT_W-1:0]                     tail;
    } req_packet_s;

endpackage

// File: rtl/flit_packetizer.sv
// Flit packetizer: pops one request packet from the FIFO, buffers it and
// streams head, body[0..BODY_FLITS-1], tail flits with a valid/ready link.
// Ports: clk, resetn (async, active-low); pkt_din, fifo_empty, fifo_rreq
// (FIFO side); o_flit, valid_out, ready_in, o_last (link side);
// busy, pkt_sent_cnt (status).
module flit_packetizer
    import ni_pkg::*;
    import fsm_pkg::*;
#(
    parameter int unsigned FLIT_W     = NI_FLIT_W,
    parameter int unsigned BODY_FLITS = NI_BODY_FLITS
) (
    input  logic              clk,
    input  logic              resetn,
    input  req_packet_s       pkt_din,
    input  logic              fifo_empty,
    output logic              fifo_rreq,
    output logic [FLIT_W-1:0] o_flit,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              o_last,
    output logic              busy,
    output logic [15:0]       pkt_sent_cnt
);

    localparam int unsigned IDX_W = (BODY_FLITS > 1) ? $clog2(BODY_FLITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BODY_FLITS - 1);

    pktz_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    req_packet_s      buf_q, buf_d;
    logic [15:0]      cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = RREQ;
            end
            RREQ: begin
                state_d = LOAD;
            end
            // FIFO read data is valid the cycle after the pop strobe.
            LOAD: begin
                buf_d   = pkt_din;
                idx_d   = '0;
                state_d = SEND_HEAD;
            end
            SEND_HEAD: begin
                if (ready_in) state_d = SEND_BODY;
            end
            SEND_BODY: begin
                if (ready_in) begin
                    if (idx_q == LAST_IDX) state_d = SEND_TAIL;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            // fifo_empty is only sampled here, so it cannot disturb
            // the packet already in flight.
            SEND_TAIL: begin
                if (ready_in) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = fifo_empty ? IDLE : RREQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only; ready_in never reaches them.
    always_comb begin
        o_flit = '0;
        case (state_q)
            SEND_HEAD: o_flit = buf_q.head;
            SEND_BODY: o_flit = buf_q.body[idx_q];
            SEND_TAIL: o_flit = buf_q.tail;
            default:   o_flit = '0;
        endcase
    end

    assign fifo_rreq    = (state_q == RREQ);
    assign valid_out    = (state_q == SEND_HEAD) ||
                          (state_q == SEND_BODY) ||
                          (state_q == SEND_TAIL);
    assign o_last       = (state_q == SEND_TAIL);
    assign busy         = (state_q != IDLE);
    assign pkt_sent_cnt = cnt_q;

endmodule

// File: doc/flit_packetizer.md
FLIT_PACKETIZER -- requirements
Module: flit_packetizer

Interface
REQ-001 Parameter FLIT_W, default 16, flit width in bits; it SHALL equal the req_packet_s flit width.
REQ-002 Parameter BODY_FLITS, default 3, number of body flits per packet; it SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 pkt_din  input  req_packet_s  packet from the request FIFO read port, valid the cycle after fifo_rreq.
REQ-006 fifo_empty  input  1  request FIFO holds no packet.
REQ-007 fifo_rreq  output  1  single-cycle FIFO pop strobe.
REQ-008 o_flit  output  FLIT_W  flit toward the NoC link.
REQ-009 valid_out  output  1  o_flit carries a valid flit.
REQ-010 ready_in  input  1  downstream accepts o_flit this cycle.
REQ-011 o_last  output  1  o_flit is the tail flit.
REQ-012 busy  output  1  a packet is loaded or in flight.
REQ-013 pkt_sent_cnt  output  16  count of packets whose tail was accepted.

Function
REQ-014 The FSM SHALL use the states IDLE, RREQ, LOAD, SEND_HEAD, SEND_BODY and SEND_TAIL.
REQ-015 IDLE: the FSM SHALL go to RREQ when fifo_empty=0, and otherwise stay in IDLE.
REQ-016 RREQ: fifo_rreq SHALL be 1 for exactly this one cycle, then the FSM SHALL go to LOAD.
REQ-017 LOAD: the block SHALL register pkt_din into an internal packet buffer, clear the beat index to 0, and go to SEND_HEAD.
REQ-018 SEND_* states: valid_out SHALL be 1 and o_flit SHALL come from the registered buffer (head, body[idx], tail respectively); no combinational path from pkt_din to o_flit is permitted.
REQ-019 A flit SHALL advance only on a cycle with valid_out=1 and ready_in=1.
REQ-020 While ready_in=0, o_flit, o_last and valid_out SHALL hold stable.
REQ-021 SEND_HEAD SHALL go to SEND_BODY on acceptance.
REQ-022 SEND_BODY SHALL increment idx on each acceptance, and SHALL go to SEND_TAIL when the flit with idx=BODY_FLITS-1 is accepted.
REQ-023 o_last SHALL be 1 only in SEND_TAIL.
REQ-024 On tail acceptance, pkt_sent_cnt SHALL increment and wrap from 0xFFFF to 0x0000.
REQ-025 On tail acceptance, the FSM SHALL go to RREQ if fifo_empty=0 (back-to-back, with no IDLE cycle), and otherwise to IDLE.
REQ-026 With continuous ready_in=1, a packet SHALL occupy BODY_FLITS+4 cycles from RREQ to tail acceptance; the head SHALL appear 2 cycles after fifo_rreq.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 fifo_rreq SHALL never assert while fifo_empty=1, and at most once per packet.
REQ-029 fifo_empty rising during a transmission SHALL have no effect on the packet in flight.
REQ-030 Outputs SHALL be registered, or decoded only from registered state; none SHALL depend combinationally on ready_in.

Reset
REQ-031 On resetn=0, the FSM SHALL enter IDLE, and fifo_rreq, valid_out, o_last, busy, o_flit and pkt_sent_cnt SHALL become 0.
REQ-032 Reset asserted mid-packet SHALL drop the partial packet; the FIFO entry already popped is lost and SHALL NOT be re-read.
REQ-033 The first fifo_rreq after resetn deasserts SHALL come no earlier than the second rising clk edge.

Structure
REQ-034 req_packet_s SHALL come from ni_pkg, and the packetizer state enum SHALL be added to fsm_pkg.
REQ-035 The block SHALL use no sub-modules: one FSM, one beat index, one packet buffer and one packet counter.

Verification
REQ-036 Scenario 1: one packet, head=0xA001, body=0xB001/0xB002/0xB003, tail=0xC001, ready_in=1 -> flits appear in that order on 5 consecutive cycles, o_last=1 only on 0xC001, and pkt_sent_cnt=1.
REQ-037 Scenario 2: ready_in=0 for 3 cycles during body[1]=0xB002 -> o_flit holds 0xB002 with valid_out=1, with no duplicate and no skipped flit.
REQ-038 Scenario 3: two packets queued, ready_in=1 -> fifo_rreq pulses twice, the second exactly 1 cycle after the first tail acceptance, with busy=1 throughout.
REQ-039 Scenario 4: resetn=0 asserted while the head=0xA001 packet is on body[0] -> all outputs become 0 immediately; after release with fifo_empty=1 the block stays IDLE with valid_out=0.
REQ-040 Scenario 5: pkt_sent_cnt preset near wrap by sending 65536 packets -> the count reads 0x0000 after the last tail.
REQ-041 Scenario 6: fifo_empty=1 for 100 cycles -> fifo_rreq and valid_out stay 0.
